// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-outstanding memory backend.
// Data has priority; a streak counter lets fetch in after two back-to-back data wins.
module mem_arbiter #(
    parameter int AW      = 10,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [31:0]   i_rdata,
    output logic          i_done,
    output logic          i_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic [31:0]   d_rdata,
    output logic          d_done,
    output logic          d_stall,
    output logic          bk_req,
    output logic          bk_we,
    output logic [3:0]    bk_be,
    output logic [AW-1:0] bk_addr,
    output logic [31:0]   bk_wdata,
    input  logic          bk_ack,
    input  logic [31:0]   bk_rdata,
    output logic          err,
    input  logic          err_clr
);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

    state_t        state_q, state_d;
    logic [1:0]    streak_q, streak_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          bk_we_q, bk_we_d;
    logic [3:0]    bk_be_q, bk_be_d;
    logic [AW-1:0] bk_addr_q, bk_addr_d;
    logic [31:0]   bk_wdata_q, bk_wdata_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          i_done_q, i_done_d;
    logic          d_done_q, d_done_d;
    logic          err_q, err_d;
    logic          grant_d, grant_i;

    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        wait_d     = wait_q;
        bk_we_d    = bk_we_q;
        bk_be_d    = bk_be_q;
        bk_addr_d  = bk_addr_q;
        bk_wdata_d = bk_wdata_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        i_done_d   = 1'b0;
        d_done_d   = 1'b0;
        err_d      = err_q;
        grant_d    = 1'b0;
        grant_i    = 1'b0;

        if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // Hold off all grants while a done pulse is out so a requester's
                // still-high req is only re-sampled the cycle after its done.
                if (!i_done_q && !d_done_q) begin
                    grant_d = d_req && !(i_req && streak_q == 2'd2);
                    grant_i = i_req && !grant_d;
                end
            end
            I_BUSY, D_BUSY: begin
                if (bk_ack) begin
                    state_d = IDLE;
                    if (state_q == I_BUSY) begin
                        i_rdata_d = bk_rdata;
                        i_done_d  = 1'b1;
                    end else begin
                        if (!bk_we_q) begin
                            d_rdata_d = bk_rdata;
                        end
                        d_done_d = 1'b1;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    if (state_q == I_BUSY) begin
                        i_rdata_d = 32'h0;
                        i_done_d  = 1'b1;
                    end else begin
                        d_rdata_d = 32'h0;
                        d_done_d  = 1'b1;
                    end
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_d) begin
            state_d    = D_BUSY;
            wait_d     = '0;
            bk_we_d    = d_we;
            bk_be_d    = d_be;
            bk_addr_d  = d_addr;
            bk_wdata_d = d_wdata;
            if (i_req && streak_q != 2'd2) begin
                streak_d = streak_q + 2'd1;
            end
        end else if (grant_i) begin
            state_d    = I_BUSY;
            wait_d     = '0;
            streak_d   = 2'd0;
            bk_we_d    = 1'b0;
            bk_be_d    = 4'hF;
            bk_addr_d  = i_addr;
            bk_wdata_d = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            streak_q   <= 2'd0;
            wait_q     <= '0;
            bk_we_q    <= 1'b0;
            bk_be_q    <= 4'h0;
            bk_addr_q  <= '0;
            bk_wdata_q <= 32'h0;
            i_rdata_q  <= 32'h0;
            d_rdata_q  <= 32'h0;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            wait_q     <= wait_d;
            bk_we_q    <= bk_we_d;
            bk_be_q    <= bk_be_d;
            bk_addr_q  <= bk_addr_d;
            bk_wdata_q <= bk_wdata_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            i_done_q   <= i_done_d;
            d_done_q   <= d_done_d;
            err_q      <= err_d;
        end
    end

    assign bk_req   = (state_q != IDLE);
    assign bk_we    = bk_we_q;
    assign bk_be    = bk_be_q;
    assign bk_addr  = bk_addr_q;
    assign bk_wdata = bk_wdata_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign i_done   = i_done_q;
    assign d_done   = d_done_q;
    assign err      = err_q;
    assign i_stall  = i_req & ~i_done_q;
    assign d_stall  = d_req & ~d_done_q;

endmodule
